mole_spawner: RTL and testbench

//  Upstream stage of the hit judge: runs one game of ROUNDS mole appearances.

---
 rtl/mole_spawner_pkg.sv | 25 ++
 rtl/mole_spawner_tick_gen.sv | 25 ++
 rtl/mole_spawner.sv | 176 +++++++++++++++++
 tb/tb_mole_spawner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mole_spawner_pkg.sv
// Shared definitions for the mole spawner: FSM encodings, LFSR taps, LED width
// and small arithmetic helpers.
package mole_spawner_pkg;

   localparam int LED_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GAP  = 2'd1;
   localparam logic [1:0] ST_SHOW = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Fibonacci taps 8,6,5,4 as a bit mask over lfsr[7:0]
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] v, input logic [7:0] seed);
      logic [7:0] n;
      n = {v[6:0], ^(v & LFSR_TAPS)};
      return (n == 8'h00) ? seed : n;
   endfunction

endpackage

// File: rtl/mole_spawner_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, phase set only by reset.
module mole_spawner_tick_gen #(
   parameter int unsigned TICK_DIV = 50_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == CW'(TICK_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mole_spawner.sv
// Runs one game of ROUNDS mole windows: dark gap, one lit hole, close on hit or timeout.
// The window shrinks by SHOW_STEP every HITS_PER_LEVEL hits, floored at SHOW_MIN.
module mole_spawner
   import mole_spawner_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 50_000,
   parameter int unsigned GAP_TICKS      = 300,
   parameter int unsigned SHOW_INIT      = 1000,
   parameter int unsigned SHOW_MIN       = 200,
   parameter int unsigned SHOW_STEP      = 100,
   parameter int unsigned HITS_PER_LEVEL = 4,
   parameter int unsigned ROUNDS         = 32,
   parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             hit,
   output logic [LED_W-1:0] led,
   output logic             judge_dis,
   output logic             busy,
   output logic             done,
   output logic [7:0]       hits,
   output logic [7:0]       misses
);

   localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);
   localparam logic [15:0] INIT16    = 16'(SHOW_INIT);
   localparam logic [15:0] MIN16     = 16'(SHOW_MIN);
   localparam logic [15:0] STEP16    = 16'(SHOW_STEP);
   localparam logic [16:0] FLOOR17   = 17'(SHOW_MIN) + 17'(SHOW_STEP);
   localparam logic [7:0]  ROUNDS8   = 8'(ROUNDS);
   localparam logic [7:0]  HPL8      = 8'(HITS_PER_LEVEL);

   logic             tick;
   logic [1:0]       state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [15:0]      show_len_q, show_len_d;
   logic [7:0]       round_q, round_d;
   logic [7:0]       hits_q, hits_d;
   logic [7:0]       misses_q, misses_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [2:0]       pos_q, pos_d;
   logic [2:0]       last_pos_q, last_pos_d;
   logic [LED_W-1:0] led_q, led_d;
   logic [2:0]       hit_sync_q, hit_sync_d;
   logic             start_prev_q, start_prev_d;

   logic             hit_rise;
   logic             start_rise;
   logic             close;
   logic [2:0]       new_pos;
   logic [7:0]       hits_inc;
   logic [7:0]       round_inc;

   mole_spawner_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign hit_rise   = hit_sync_q[1] & ~hit_sync_q[2];
   assign start_rise = start & ~start_prev_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      show_len_d   = show_len_q;
      round_d      = round_q;
      hits_d       = hits_q;
      misses_d     = misses_q;
      pos_d        = pos_q;
      last_pos_d   = last_pos_q;
      led_d        = led_q;
      lfsr_d       = lfsr_next(lfsr_q, LFSR_SEED);
      hit_sync_d   = {hit_sync_q[1:0], hit};
      start_prev_d = start;
      close        = 1'b0;
      hits_inc     = sat_inc8(hits_q);
      round_inc    = sat_inc8(round_q);

      // Never repeat the previous hole back-to-back
      new_pos = lfsr_q[2:0];
      if (new_pos == last_pos_q) new_pos = new_pos + 3'd1;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_rise) begin
               state_d    = ST_GAP;
               cnt_d      = '0;
               hits_d     = '0;
               misses_d   = '0;
               round_d    = '0;
               show_len_d = INIT16;
            end
         end
         ST_GAP: begin
            if (tick) begin
               if (cnt_q == GAP_LAST) begin
                  state_d = ST_SHOW;
                  cnt_d   = '0;
                  pos_d   = new_pos;
                  led_d   = LED_W'(1) << new_pos;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         ST_SHOW: begin
            // A hit on the expiry cycle takes priority over the timeout
            if (hit_rise) begin
               hits_d = hits_inc;
               close  = 1'b1;
               if ((hits_inc % HPL8) == 8'd0) begin
                  show_len_d = ({1'b0, show_len_q} <= FLOOR17) ? MIN16 : show_len_q - STEP16;
               end
            end else if (tick) begin
               if (cnt_q == show_len_q - 16'd1) begin
                  misses_d = sat_inc8(misses_q);
                  close    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (close) begin
         led_d      = '0;
         cnt_d      = '0;
         round_d    = round_inc;
         last_pos_d = pos_q;
         state_d    = (round_inc == ROUNDS8) ? ST_DONE : ST_GAP;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         show_len_q   <= INIT16;
         round_q      <= '0;
         hits_q       <= '0;
         misses_q     <= '0;
         lfsr_q       <= LFSR_SEED;
         pos_q        <= '0;
         last_pos_q   <= '0;
         led_q        <= '0;
         hit_sync_q   <= '0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         show_len_q   <= show_len_d;
         round_q      <= round_d;
         hits_q       <= hits_d;
         misses_q     <= misses_d;
         lfsr_q       <= lfsr_d;
         pos_q        <= pos_d;
         last_pos_q   <= last_pos_d;
         led_q        <= led_d;
         hit_sync_q   <= hit_sync_d;
         start_prev_q <= start_prev_d;
      end
   end

   // Board goes dark as soon as reset is asserted, not one edge later
   assign led       = rst_n ? led_q : '0;
   assign judge_dis = ~((state_q == ST_SHOW) && (led != '0));
   assign busy      = (state_q == ST_GAP) || (state_q == ST_SHOW);
   assign done      = (state_q == ST_DONE);
   assign hits      = hits_q;
   assign misses    = misses_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench: stimulus queues expected window/game results, a monitor checks them.
module tb_mole_spawner;

   logic       clk = 1'b0;
   logic       rst_n, start, hit;
   logic [7:0] led, hits, misses;
   logic       judge_dis, busy, done;

   always #5 clk = ~clk;

   mole_spawner #(
      .TICK_DIV(4), .GAP_TICKS(2), .SHOW_INIT(6), .SHOW_MIN(2), .SHOW_STEP(2),
      .HITS_PER_LEVEL(2), .ROUNDS(4), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .led(led),
      .judge_dis(judge_dis), .busy(busy), .done(done), .hits(hits), .misses(misses)
   );

   typedef struct {
      bit is_done;
      int width;
      int hits;
      int misses;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // mode: 0 no hit, 1 hit 2 clks in, 2 hit landing on expiry, 3 hit one clk too late
   int   mode_t  [5][4];
   int   width_t [5][4];
   bit   gaphit_t[5];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin : monitor
      logic [7:0] led_prev  = 8'h00;
      logic [7:0] last_led  = 8'h01;
      bit         done_prev = 1'b0;
      int         width     = 0;
      exp_t       e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n !== 1'b1) begin
            led_prev  = 8'h00;
            last_led  = 8'h01;
            done_prev = 1'b0;
            width     = 0;
         end else begin
            if (led != 8'h00) begin
               if (led_prev == 8'h00) begin
                  chk("led_onehot", $countones(led), 1);
                  chk("pos_repeat", int'(led == last_led), 0);
                  chk("judge_en_in_show", int'(judge_dis), 0);
                  last_led = led;
               end
               width++;
            end else if (led_prev != 8'h00) begin
               chk("judge_dis_after_show", int'(judge_dis), 1);
               chk("sb_has_win", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("win_kind", int'(e.is_done), 0);
                  chk("win_width", width, e.width);
                  chk("win_hits", int'(hits), e.hits);
                  chk("win_misses", int'(misses), e.misses);
               end
               width = 0;
            end
            if (done && !done_prev) begin
               chk("sb_has_done", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("done_kind", int'(e.is_done), 1);
                  chk("done_hits", int'(hits), e.hits);
                  chk("done_misses", int'(misses), e.misses);
               end
            end
            led_prev  = led;
            done_prev = done;
         end
      end
   end

   task automatic wait_led(input bit on, input int budget, input string name);
      int n = 0;
      while (((led != 8'h00) != on) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'((led != 8'h00) == on), 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic play_window(input int mode, input int width, input bit gap_hit);
      int off;
      wait_led(1'b1, 60, "led_on_timeout");
      if (mode != 0) begin
         off = (mode == 1) ? 2 : (mode == 2) ? width - 3 : width - 2;
         repeat (off) @(negedge clk);
         hit = 1'b1;
         repeat (3) @(negedge clk);
         hit = 1'b0;
      end
      wait_led(1'b0, 40, "led_off_timeout");
      if (gap_hit) begin
         hit = 1'b1;
         repeat (2) @(negedge clk);
         hit = 1'b0;
      end
   endtask

   task automatic run_game(input int g);
      int h = 0;
      int m = 0;
      int n = 0;
      for (int w = 0; w < 4; w++) begin
         if (mode_t[g][w] == 1 || mode_t[g][w] == 2) h++;
         else m++;
         sb.push_back('{is_done: 1'b0, width: width_t[g][w], hits: h, misses: m});
      end
      sb.push_back('{is_done: 1'b1, width: 0, hits: h, misses: m});
      pulse_start();
      for (int w = 0; w < 4; w++) begin
         play_window(mode_t[g][w], width_t[g][w], gaphit_t[g]);
         if (g == 3 && w == 1) pulse_start();
      end
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
      chk("end_done", int'(done), 1);
      chk("end_busy", int'(busy), 0);
      chk("end_led", int'(led), 0);
      chk("end_judge_dis", int'(judge_dis), 1);
      chk("end_hits", int'(hits), h);
      chk("end_misses", int'(misses), m);
   endtask

   initial begin : stim
      mode_t   = '{'{0,0,0,0}, '{1,1,1,1}, '{1,1,0,0}, '{2,3,0,0}, '{0,0,0,0}};
      width_t  = '{'{24,24,24,24}, '{5,5,5,5}, '{5,5,16,16}, '{24,24,24,24}, '{24,24,24,24}};
      gaphit_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      hit   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("rst_led", int'(led), 0);
      chk("rst_judge_dis", int'(judge_dis), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_hits", int'(hits), 0);
      chk("rst_misses", int'(misses), 0);

      for (int g = 0; g < 4; g++) run_game(g);

      // Reset in the middle of the second window
      sb.push_back('{is_done: 1'b0, width: 5, hits: 1, misses: 0});
      pulse_start();
      play_window(1, 5, 1'b0);
      wait_led(1'b1, 60, "led_on_before_rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_led_immediate", int'(led), 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_led", int'(led), 0);
      chk("midrst_judge_dis", int'(judge_dis), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_hits", int'(hits), 0);
      chk("midrst_misses", int'(misses), 0);
      chk("midrst_sb_empty", sb.size(), 0);
      repeat (2) @(negedge clk);

      run_game(4);
      chk("final_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
